acc_datapath: RTL and testbench

ACC_DATAPATH -- requirements
Module: acc_datapath

---
 rtl/acc_datapath_pkg.sv | 44 ++++
 rtl/acc_datapath_if.sv | 41 ++++
 rtl/acc_alu.sv | 63 ++++++
 rtl/acc_datapath.sv | 145 ++++++++++++++
 tb/tb_acc_datapath.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_datapath_pkg.sv
// ============================================================================
// acc_datapath_pkg : opcodes, accumulator source selects, FSM states, flags
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_datapath_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SRA = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      SELA_MEM  = 2'b00,
      SELA_ALU  = 2'b01,
      SELA_IMM  = 2'b10,
      SELA_HOLD = 2'b11
   } sela_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

   localparam int C_W_FLAGS = 4;

endpackage

`default_nettype wire

// File: rtl/acc_datapath_if.sv
// ============================================================================
// acc_datapath_if : request/response bundle between requester and datapath
// Rev 1.0
// ============================================================================
`default_nettype none

interface acc_datapath_if
   import acc_datapath_pkg::*;
#(
   parameter int NBITS_O = 11,
   parameter int NBITS_D = 16,
   parameter int N_ACC   = 4
);
   localparam int W_IDX = (N_ACC > 1) ? $clog2(N_ACC) : 1;

   logic                 i_valid;
   logic                 o_ready;
   logic [W_IDX-1:0]     i_acc_idx;
   logic [1:0]           i_SelA;
   logic                 i_SelB;
   logic                 i_WrAcc;
   logic [2:0]           i_Op;
   logic [NBITS_O-1:0]   i_Operand;
   logic [NBITS_D-1:0]   i_OutData;
   logic [NBITS_D-1:0]   o_acc;
   logic [C_W_FLAGS-1:0] o_flags;
   logic                 o_done;

   modport master (
      output i_valid, i_acc_idx, i_SelA, i_SelB, i_WrAcc, i_Op, i_Operand, i_OutData,
      input  o_ready, o_acc, o_flags, o_done
   );

   modport slave (
      input  i_valid, i_acc_idx, i_SelA, i_SelB, i_WrAcc, i_Op, i_Operand, i_OutData,
      output o_ready, o_acc, o_flags, o_done
   );

endinterface

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
// acc_alu : single-cycle ALU (add/sub/logic/shifts) with Z/N/C/V flags
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_alu
   import acc_datapath_pkg::*;
#(
   parameter int NBITS_D = 16
)(
   input  wire  [NBITS_D-1:0] i_a,
   input  wire  [NBITS_D-1:0] i_b,
   input  wire  [2:0]         i_op,
   output logic [NBITS_D-1:0] o_result,
   output flags_t             o_flags
);

   localparam int              W_SH = $clog2(NBITS_D) + 1;
   localparam int              MSB  = NBITS_D - 1;
   localparam logic [W_SH-1:0] C_NB = W_SH'(NBITS_D);

   logic [W_SH-1:0]  w_amt;
   logic [NBITS_D:0] w_sum;
   logic             w_c;
   logic             w_v;

   assign w_amt = i_b[W_SH-1:0];

   always_comb begin
      o_result = '0;
      w_sum    = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (op_e'(i_op))
         OP_ADD: begin
            w_sum    = {1'b0, i_a} + {1'b0, i_b};
            o_result = w_sum[MSB:0];
            w_c      = w_sum[NBITS_D];
            w_v      = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
         end
         OP_SUB: begin
            // Carry is the carry-out of A + ~B + 1 (i.e. set when no borrow)
            w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{NBITS_D{1'b0}}, 1'b1};
            o_result = w_sum[MSB:0];
            w_c      = w_sum[NBITS_D];
            w_v      = (i_a[MSB] != i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
         end
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_XOR: o_result = i_a ^ i_b;
         OP_SHL: o_result = (w_amt >= C_NB) ? '0 : (i_a << w_amt);
         OP_SRA: o_result = (w_amt >= C_NB) ? {NBITS_D{i_a[MSB]}}
                                            : NBITS_D'($signed(i_a) >>> w_amt);
         default: o_result = '0;
      endcase
   end

   assign o_flags = {(o_result == '0), o_result[MSB], w_c, w_v};

endmodule

`default_nettype wire

// File: rtl/acc_datapath.sv
// ============================================================================
// acc_datapath : accumulator array, request FSM and iterative shift-add MUL
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_datapath
   import acc_datapath_pkg::*;
#(
   parameter int NBITS_O = 11,
   parameter int NBITS_D = 16,
   parameter int N_ACC   = 4
)(
   input wire            i_clock,
   input wire            i_reset,
   acc_datapath_if.slave bus
);

   localparam int              W_IDX  = (N_ACC > 1) ? $clog2(N_ACC) : 1;
   localparam int              W_CNT  = (NBITS_D > 1) ? $clog2(NBITS_D) : 1;
   localparam int              MSB    = NBITS_D - 1;
   localparam logic [W_CNT-1:0] C_LAST = W_CNT'(NBITS_D - 1);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [NBITS_D-1:0] r_acc [N_ACC];
   logic [NBITS_D-1:0] r_oacc;
   flags_t             r_flags;
   logic [NBITS_D-1:0] r_mcand;
   logic [NBITS_D-1:0] r_mplier;
   logic [NBITS_D-1:0] r_prod;
   logic [W_CNT-1:0]   r_cnt;
   logic [W_IDX-1:0]   r_idx;
   logic               r_wr;

   logic [NBITS_D-1:0] w_ext;
   logic [NBITS_D-1:0] w_a;
   logic [NBITS_D-1:0] w_b;
   logic [NBITS_D-1:0] w_alu_res;
   flags_t             w_alu_flags;
   logic [NBITS_D-1:0] w_wdata;
   logic [NBITS_D-1:0] w_prod_nxt;
   sela_e              w_sela;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_wr_now;
   logic               w_mul_fin;

   generate
      if (NBITS_O >= NBITS_D) begin : g_ext_trunc
         assign w_ext = bus.i_Operand[NBITS_D-1:0];
      end else begin : g_ext_sign
         assign w_ext = {{(NBITS_D-NBITS_O){bus.i_Operand[NBITS_O-1]}}, bus.i_Operand};
      end
   endgenerate

   assign w_sela     = sela_e'(bus.i_SelA);
   assign w_accept   = (r_state == ST_IDLE) && bus.i_valid;
   assign w_is_mul   = (op_e'(bus.i_Op) == OP_MUL) && (w_sela == SELA_ALU);
   assign w_a        = r_acc[bus.i_acc_idx];
   assign w_b        = bus.i_SelB ? w_ext : bus.i_OutData;
   assign w_wr_now   = w_accept && !w_is_mul && bus.i_WrAcc && (w_sela != SELA_HOLD);
   assign w_mul_fin  = (r_state == ST_MUL) && (r_cnt == C_LAST);
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

   acc_alu #(
      .NBITS_D (NBITS_D)
   ) u_alu (
      .i_a      (w_a),
      .i_b      (w_b),
      .i_op     (bus.i_Op),
      .o_result (w_alu_res),
      .o_flags  (w_alu_flags)
   );

   always_comb begin
      w_wdata = w_a;
      case (w_sela)
         SELA_MEM: w_wdata = bus.i_OutData;
         SELA_ALU: w_wdata = w_alu_res;
         SELA_IMM: w_wdata = w_ext;
         default:  w_wdata = w_a;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.i_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
         ST_MUL:  if (r_cnt == C_LAST) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operands are latched at acceptance so an in-flight MUL ignores later input changes
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < N_ACC; k++) r_acc[k] <= '0;
         r_oacc   <= '0;
         r_flags  <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_wr     <= 1'b0;
      end else if (w_accept) begin
         r_oacc   <= w_wr_now ? w_wdata : w_a;
         r_mcand  <= w_a;
         r_mplier <= w_b;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_idx    <= bus.i_acc_idx;
         r_wr     <= bus.i_WrAcc;
         if (w_wr_now) begin
            r_acc[bus.i_acc_idx] <= w_wdata;
            if (w_sela == SELA_ALU) r_flags <= w_alu_flags;
         end
      end else if (r_state == ST_MUL) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_mul_fin && r_wr) begin
            r_acc[r_idx] <= w_prod_nxt;
            r_oacc       <= w_prod_nxt;
            r_flags      <= {(w_prod_nxt == '0), w_prod_nxt[MSB], 2'b00};
         end
      end
   end

   assign bus.o_ready = (r_state == ST_IDLE);
   assign bus.o_done  = (r_state == ST_DONE);
   assign bus.o_acc   = r_oacc;
   assign bus.o_flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_acc_datapath.sv
// ============================================================================
// tb_acc_datapath : directed scoreboard bench for acc_datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_datapath;

   localparam int NBITS_O = 11;
   localparam int NBITS_D = 16;
   localparam int N_ACC   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   acc_datapath_if #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .N_ACC(N_ACC)) bus ();

   acc_datapath #(
      .NBITS_O (NBITS_O),
      .NBITS_D (NBITS_D),
      .N_ACC   (N_ACC)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   typedef struct {
      string       tag;
      logic [15:0] acc;
      logic [3:0]  flags;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] m_acc [4];
   logic [3:0]  m_flags;
   logic [15:0] last_acc;
   logic [3:0]  last_flags;
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference ALU: returns {Z,N,C,V,result}
   function automatic logic [19:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        c, v;
      int          sa, sb, sr, amt;
      r = '0; c = 1'b0; v = 1'b0; s = '0;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      amt = int'(b[4:0]);
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                     sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
         3'd1: begin r = a - b; c = (a >= b);
                     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (amt >= 16) ? 16'h0000 : 16'(a << amt);
         3'd6: begin sr = sa >>> amt; r = sr[15:0]; end
         default: begin sr = int'(a) * int'(b); r = sr[15:0]; end
      endcase
      return {(r == 16'h0000), r[15], c, v, r};
   endfunction

   task automatic issue(input string tag, input int idx, input logic [1:0] sela, input logic selb,
                        input logic wr, input logic [2:0] op, input logic [10:0] operand,
                        input logic [15:0] outdata, input bit noise);
      exp_t        e;
      logic [15:0] ext, a, b, w;
      logic [19:0] m;
      int          lat, rdy_low;
      ext = {{5{operand[10]}}, operand};
      a   = m_acc[idx];
      b   = selb ? ext : outdata;
      m   = model_alu(op, a, b);
      case (sela)
         2'b00:   w = outdata;
         2'b01:   w = m[15:0];
         2'b10:   w = ext;
         default: w = a;
      endcase
      if (wr && sela != 2'b11) begin
         m_acc[idx] = w;
         if (sela == 2'b01) m_flags = m[19:16];
      end
      e.tag   = tag;
      e.acc   = m_acc[idx];
      e.flags = m_flags;
      e.lat   = (op == 3'b111 && sela == 2'b01) ? NBITS_D + 1 : 1;
      sb_q.push_back(e);

      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
      bus.i_acc_idx = 2'(idx);
      bus.i_SelA    = sela;
      bus.i_SelB    = selb;
      bus.i_WrAcc   = wr;
      bus.i_Op      = op;
      bus.i_Operand = operand;
      bus.i_OutData = outdata;
      bus.i_valid   = 1'b1;
      @(posedge clk); #1;
      if (noise) begin
         bus.i_acc_idx = 2'(~idx);
         bus.i_SelA    = 2'b10;
         bus.i_SelB    = 1'b0;
         bus.i_WrAcc   = 1'b1;
         bus.i_Op      = 3'b000;
         bus.i_Operand = 11'h7FF;
         bus.i_OutData = 16'hDEAD;
      end else begin
         bus.i_valid = 1'b0;
      end
      lat = 1; rdy_low = 0;
      while (bus.o_done !== 1'b1 && lat < 64) begin
         if (bus.o_ready === 1'b0) rdy_low++;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.o_ready === 1'b0) rdy_low++;
      bus.i_valid = 1'b0;
      chk({tag, "_done"}, 32'(bus.o_done), 32'd1);
      chk({tag, "_sb_avail"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, "_acc"},   32'(bus.o_acc),   32'(e.acc));
         chk({e.tag, "_flags"}, 32'(bus.o_flags), 32'(e.flags));
         chk({e.tag, "_lat"},   32'(lat),         32'(e.lat));
         chk({e.tag, "_busy"},  32'(rdy_low),     32'(e.lat));
      end
      last_acc   = bus.o_acc;
      last_flags = bus.o_flags;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(bus.o_done), 32'd0);
   endtask

   logic [2:0]  t_op   [9] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6, 3'd5, 3'd0, 3'd0};
   logic        t_selb [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [10:0] t_imm  [9] = '{11'h0F0, 11'h000, 11'h7FF, 11'h004, 11'h003, 11'h014,
                               11'h000, 11'h000, 11'h400};
   logic [15:0] t_mem  [9] = '{16'h0000, 16'h1200, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0010, 16'h8000, 16'h0000};

   initial begin
      int done_seen;
      bus.i_valid   = 1'b0;
      bus.i_acc_idx = '0;
      bus.i_SelA    = '0;
      bus.i_SelB    = 1'b0;
      bus.i_WrAcc   = 1'b0;
      bus.i_Op      = '0;
      bus.i_Operand = '0;
      bus.i_OutData = '0;
      for (int k = 0; k < 4; k++) m_acc[k] = 16'h0000;
      m_flags = 4'h0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_acc",   32'(bus.o_acc),   32'd0);
      chk("rst_flags", 32'(bus.o_flags), 32'd0);
      chk("rst_done",  32'(bus.o_done),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      issue("imm0", 0, 2'b10, 1'b0, 1'b1, 3'd0, 11'h07B, 16'h0000, 1'b0);
      chk("imm0_spec", 32'(last_acc), 32'h007B);
      issue("imm1", 1, 2'b10, 1'b0, 1'b1, 3'd0, 11'h47B, 16'h0000, 1'b0);
      chk("imm1_spec", 32'(last_acc), 32'hFC7B);
      issue("rd0", 0, 2'b11, 1'b0, 1'b1, 3'd0, 11'h000, 16'h0000, 1'b0);
      chk("rd0_spec", 32'(last_acc), 32'h007B);

      issue("add", 0, 2'b01, 1'b0, 1'b1, 3'd0, 11'h000, 16'hF0F0, 1'b0);
      chk("add_spec",   32'(last_acc),   32'hF16B);
      chk("add_fspec",  32'(last_flags), 32'b0100);

      issue("ld2", 2, 2'b00, 1'b0, 1'b1, 3'd0, 11'h000, 16'h8000, 1'b0);
      issue("sub", 2, 2'b01, 1'b1, 1'b1, 3'd1, 11'h001, 16'h0000, 1'b0);
      chk("sub_spec",  32'(last_acc),   32'h7FFF);
      chk("sub_fspec", 32'(last_flags), 32'b0011);
      issue("subnw", 2, 2'b01, 1'b1, 1'b0, 3'd1, 11'h001, 16'h0000, 1'b0);
      chk("subnw_spec",  32'(last_acc),   32'h7FFF);
      chk("subnw_fspec", 32'(last_flags), 32'b0011);

      for (int i = 0; i < 9; i++)
         issue($sformatf("alu%0d", i), 1, 2'b01, t_selb[i], 1'b1, t_op[i], t_imm[i], t_mem[i], 1'b0);

      issue("ld3", 3, 2'b10, 1'b0, 1'b1, 3'd0, 11'h123, 16'h0000, 1'b0);
      issue("mul", 3, 2'b01, 1'b1, 1'b1, 3'd7, 11'h010, 16'h0000, 1'b1);
      chk("mul_spec", 32'(last_acc), 32'h1230);
      issue("rd0b", 0, 2'b11, 1'b0, 1'b1, 3'd0, 11'h000, 16'h0000, 1'b0);
      issue("mulmem", 0, 2'b00, 1'b0, 1'b1, 3'd7, 11'h000, 16'h5A5A, 1'b0);

      // MUL aborted by reset partway through
      @(negedge clk);
      bus.i_acc_idx = 2'd3;
      bus.i_SelA    = 2'b01;
      bus.i_SelB    = 1'b1;
      bus.i_WrAcc   = 1'b1;
      bus.i_Op      = 3'd7;
      bus.i_Operand = 11'h011;
      bus.i_valid   = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      chk("mid_mul_busy", 32'(bus.o_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(bus.o_ready), 32'd1);
      chk("abort_acc",   32'(bus.o_acc),   32'd0);
      chk("abort_flags", 32'(bus.o_flags), 32'd0);
      chk("abort_done",  32'(bus.o_done),  32'd0);
      for (int k = 0; k < 4; k++) m_acc[k] = 16'h0000;
      m_flags   = 4'h0;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.o_done === 1'b1) done_seen++;
         if (c == 2) rst_n = 1'b1;
      end
      chk("abort_nodone", 32'(done_seen), 32'd0);
      for (int k = 0; k < 4; k++)
         issue($sformatf("clr%0d", k), k, 2'b11, 1'b0, 1'b0, 3'd0, 11'h000, 16'h0000, 1'b0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
